// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and port indices.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. A set mask bit removes that requester from
// consideration; on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  // Pick at most one eligible requester, alternating on ties.
  always_comb begin
    eligible = req & ~mask;
    gnt      = '0;
    if (eligible == 2'b11) begin
      gnt = (last_grant == P0) ? 2'b10 : 2'b01;
    end else begin
      gnt = eligible;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the CPU LSU (port 0) and the
// DMA/debug loader (port 1). Round-robin grant, optional bounded lock,
// registered read return with a one-cycle rvalid pulse.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       mask;
  logic [1:0]       gnt_raw;
  logic [1:0]       gnt;

  // A lock masks off the port that does not own the memory.
  always_comb begin
    mask = '0;
    case (state)
      ST_LOCK0: mask = 2'b10;
      ST_LOCK1: mask = 2'b01;
      default:  mask = '0;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .mask       (mask),
    .gnt        (gnt_raw)
  );

  // Grant and memory drive; everything is held quiet while reset is low.
  always_comb begin
    gnt        = rst_n ? gnt_raw : '0;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (gnt[0]) begin
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      mem_read  = ~req0_we;
      mem_write = req0_we;
    end else if (gnt[1]) begin
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      mem_read  = ~req1_we;
      mem_write = req1_we;
    end
  end

  // Lock FSM, round-robin history and registered read return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= P1;
      lock_cnt    <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      if (gnt[0] && !req0_we) begin
        req0_rvalid <= 1'b1;
        req0_rdata  <= mem_rdata;
      end
      if (gnt[1] && !req1_we) begin
        req1_rvalid <= 1'b1;
        req1_rdata  <= mem_rdata;
      end

      if (gnt[0]) begin
        last_grant <= P0;
      end else if (gnt[1]) begin
        last_grant <= P1;
      end

      case (state)
        ST_IDLE: begin
          if (gnt[0] && req0_lock) begin
            state    <= ST_LOCK0;
            lock_cnt <= '0;
          end else if (gnt[1] && req1_lock) begin
            state    <= ST_LOCK1;
            lock_cnt <= '0;
          end
        end
        // The bound check comes first so a lock request in the final
        // cycle cannot extend ownership.
        ST_LOCK0: begin
          if (lock_cnt == CNT_LAST || (gnt[0] && !req0_lock)) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        ST_LOCK1: begin
          if (lock_cnt == CNT_LAST || (gnt[1] && !req1_lock)) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, a forced-release sequence,
// and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Environment memory: combinational read, write at the clock edge.
  logic [DATA_W-1:0] tbmem [256] = '{default: '0};
  assign mem_rdata = tbmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) tbmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst;
    bit v0, we0, lk0; logic [31:0] a0, d0;
    bit v1, we1, lk1; logic [31:0] a1, d1;
    bit er0, er1, erd, ewr; logic [31:0] eaddr, ewd;
    bit erv0, erv1; logic [31:0] erd0, erd1;
  } vec_t;

  function automatic vec_t mk(bit rst, bit v0, bit we0, bit lk0, logic [31:0] a0, logic [31:0] d0,
                              bit v1, bit we1, bit lk1, logic [31:0] a1, logic [31:0] d1,
                              bit er0, bit er1, bit erd, bit ewr, logic [31:0] eaddr, logic [31:0] ewd,
                              bit erv0, bit erv1, logic [31:0] erd0, logic [31:0] erd1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.erd = erd; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd;
    v.erv0 = erv0; v.erv1 = erv1; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  task automatic drive_idle();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  // ---------------- reference model ----------------
  int          m_owner;   // -1: nobody owns the memory
  int          m_age;     // cycles spent owned since the locking transaction
  int          m_last;
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic [31:0] mref [256];

  function automatic logic pv(int p); return p == 0 ? req0_valid : req1_valid; endfunction
  function automatic logic pwe(int p); return p == 0 ? req0_we : req1_we; endfunction
  function automatic logic plk(int p); return p == 0 ? req0_lock : req1_lock; endfunction
  function automatic logic [31:0] pa(int p); return p == 0 ? req0_addr : req1_addr; endfunction
  function automatic logic [31:0] pd(int p); return p == 0 ? req0_wdata : req1_wdata; endfunction

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_owner >= 0) return pv(m_owner) ? m_owner : -1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic [31:0] a;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_age = 0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0;
      if (g >= 0) begin
        m_last = g;
        a = pa(g);
        if (pwe(g)) mref[a[9:2]] = pd(g);
        else begin m_rv[g] = 1; m_rd[g] = mref[a[9:2]]; end
      end
      if (m_owner < 0) begin
        if (g >= 0 && plk(g)) begin m_owner = g; m_age = 0; end
      end else if (m_age == LOCK_MAX - 1) begin
        m_owner = -1;
      end else if (g == m_owner && !plk(g)) begin
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic new_req(input int p);
    logic        v, we, lk;
    logic [31:0] a, d;
    v  = ($urandom_range(0, 3) != 0);
    we = $urandom_range(0, 1) == 1;
    lk = ($urandom_range(0, 3) == 0);
    a  = ($urandom & 32'h0000_F000) | (32'($urandom_range(0, 15)) << 2);
    d  = $urandom;
    if (p == 0) begin req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d; end
  endtask

  localparam logic [31:0] DB  = 32'hDEADBEEF, W11 = 32'h11111111, W22 = 32'h22222222;
  localparam logic [31:0] A1  = 32'hA1A1A1A1, A2 = 32'hA2A2A2A2, A3 = 32'hA3A3A3A3;
  localparam logic [31:0] CF  = 32'hCAFEF00D, BAD = 32'h00000BAD;

  vec_t tbl [32];

  initial begin
    // Table rows: inputs for one cycle, then outputs expected before that edge.
    tbl[0]  = mk(0, 0,0,0,0,0,        1,1,0,32'h20,32'h55, 0,0,0,0,0,0,          0,0,0,0);
    tbl[1]  = mk(1, 1,1,0,32'h10,DB,  0,0,0,0,0,           1,0,0,1,32'h10,DB,    0,0,0,0);
    tbl[2]  = mk(1, 1,0,0,32'h10,0,   0,0,0,0,0,           1,0,1,0,32'h10,0,     0,0,0,0);
    tbl[3]  = mk(1, 0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,0,          1,0,DB,0);
    tbl[4]  = mk(1, 0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,0,          0,0,DB,0);
    tbl[5]  = mk(0, 0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,0,          0,0,DB,0);
    tbl[6]  = mk(1, 1,0,0,32'h10,0,   1,0,0,32'h10,0,      1,0,1,0,32'h10,0,     0,0,0,0);
    tbl[7]  = mk(1, 1,0,0,32'h10,0,   1,0,0,32'h10,0,      0,1,1,0,32'h10,0,     1,0,DB,0);
    tbl[8]  = mk(1, 1,0,0,32'h10,0,   1,0,0,32'h10,0,      1,0,1,0,32'h10,0,     0,1,DB,DB);
    tbl[9]  = mk(1, 1,0,0,32'h10,0,   1,0,0,32'h10,0,      0,1,1,0,32'h10,0,     1,0,DB,DB);
    tbl[10] = mk(1, 1,1,0,32'h30,W11, 0,0,0,0,0,           1,0,0,1,32'h30,W11,   0,1,DB,DB);
    tbl[11] = mk(1, 1,0,0,32'h10,0,   1,1,1,32'h40,A1,     0,1,0,1,32'h40,A1,    0,0,DB,DB);
    tbl[12] = mk(1, 1,0,0,32'h10,0,   1,1,1,32'h44,A2,     0,1,0,1,32'h44,A2,    0,0,DB,DB);
    tbl[13] = mk(1, 1,0,0,32'h10,0,   1,1,0,32'h48,A3,     0,1,0,1,32'h48,A3,    0,0,DB,DB);
    tbl[14] = mk(1, 1,0,0,32'h10,0,   0,0,0,0,0,           1,0,1,0,32'h10,0,     0,0,DB,DB);
    tbl[15] = mk(1, 0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,0,          1,0,DB,DB);
    tbl[16] = mk(1, 1,1,1,32'h50,W22, 0,0,0,0,0,           1,0,0,1,32'h50,W22,   0,0,DB,DB);
    for (int k = 17; k <= 24; k++)
      tbl[k] = mk(1, 0,0,0,0,0,       1,0,0,32'h40,0,      0,0,0,0,0,0,          0,0,DB,DB);
    tbl[25] = mk(1, 0,0,0,0,0,        1,0,0,32'h40,0,      0,1,1,0,32'h40,0,     0,0,DB,DB);
    tbl[26] = mk(1, 1,1,0,32'h3FC,CF, 0,0,0,0,0,           1,0,0,1,32'h3FC,CF,   0,1,DB,A1);
    tbl[27] = mk(1, 0,0,0,0,0,        1,0,1,32'h44,0,      0,1,1,0,32'h44,0,     0,0,DB,A1);
    tbl[28] = mk(0, 0,0,0,0,0,        1,1,0,32'h48,BAD,    0,0,0,0,0,0,          0,1,DB,A2);
    tbl[29] = mk(1, 1,0,0,32'h50,0,   1,0,0,32'h3FC,0,     1,0,1,0,32'h50,0,     0,0,0,0);
    tbl[30] = mk(1, 0,0,0,0,0,        1,0,0,32'h3FC,0,     0,1,1,0,32'h3FC,0,    1,0,W22,0);
    tbl[31] = mk(1, 0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,0,          0,1,W22,CF);

    // Bring registers to a known state before anything is compared.
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      rst_n = tbl[i].rst;
      req0_valid = tbl[i].v0; req0_we = tbl[i].we0; req0_lock = tbl[i].lk0;
      req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_we = tbl[i].we1; req1_lock = tbl[i].lk1;
      req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d req0_ready", i), 64'(req0_ready), 64'(tbl[i].er0));
      chk($sformatf("vec%0d req1_ready", i), 64'(req1_ready), 64'(tbl[i].er1));
      chk($sformatf("vec%0d mem_read", i), 64'(mem_read), 64'(tbl[i].erd));
      chk($sformatf("vec%0d mem_write", i), 64'(mem_write), 64'(tbl[i].ewr));
      chk($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(tbl[i].eaddr));
      chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].ewd));
      chk($sformatf("vec%0d req0_rvalid", i), 64'(req0_rvalid), 64'(tbl[i].erv0));
      chk($sformatf("vec%0d req1_rvalid", i), 64'(req1_rvalid), 64'(tbl[i].erv1));
      chk($sformatf("vec%0d req0_rdata", i), 64'(req0_rdata), 64'(tbl[i].erd0));
      chk($sformatf("vec%0d req1_rdata", i), 64'(req1_rdata), 64'(tbl[i].erd1));
      @(posedge clk);
      #1;
    end

    // Lock request repeated through the forced-release cycle must not re-lock.
    drive_idle();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    req0_valid = 1; req0_we = 0; req0_lock = 1; req0_addr = 32'h60;
    req1_valid = 1; req1_we = 0; req1_lock = 0; req1_addr = 32'h64;
    for (int c = 0; c <= LOCK_MAX + 1; c++) begin
      @(negedge clk);
      if (c <= LOCK_MAX) begin
        chk($sformatf("relock c%0d req0_ready", c), 64'(req0_ready), 64'd1);
        chk($sformatf("relock c%0d req1_ready", c), 64'(req1_ready), 64'd0);
      end else begin
        chk("relock release req0_ready", 64'(req0_ready), 64'd0);
        chk("relock release req1_ready", 64'(req1_ready), 64'd1);
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model.
    drive_idle();
    rst_n = 0;
    @(posedge clk); #1;
    m_owner = -1; m_last = 1; m_age = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    for (int k = 0; k < 256; k++) mref[k] = tbmem[k];
    rst_n = 1;
    new_req(0);
    new_req(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [31:0] ea, ew;
      logic held0, held1, was_rst;
      g  = exp_grant();
      ea = (g >= 0) ? pa(g) : '0;
      ew = (g >= 0) ? pd(g) : '0;
      @(negedge clk);
      chk("rnd req0_ready", 64'(req0_ready), 64'(g == 0));
      chk("rnd req1_ready", 64'(req1_ready), 64'(g == 1));
      chk("rnd mem_read", 64'(mem_read), 64'(g >= 0 && !pwe(g)));
      chk("rnd mem_write", 64'(mem_write), 64'(g >= 0 && pwe(g)));
      chk("rnd mem_addr", 64'(mem_addr), 64'(ea));
      chk("rnd mem_wdata", 64'(mem_wdata), 64'(ew));
      chk("rnd req0_rvalid", 64'(req0_rvalid), 64'(m_rv[0]));
      chk("rnd req1_rvalid", 64'(req1_rvalid), 64'(m_rv[1]));
      chk("rnd req0_rdata", 64'(req0_rdata), 64'(m_rd[0]));
      chk("rnd req1_rdata", 64'(req1_rdata), 64'(m_rd[1]));
      @(posedge clk);
      model_update(g);
      #1;
      was_rst = !rst_n;
      held0 = req0_valid && g != 0 && !was_rst;
      held1 = req1_valid && g != 1 && !was_rst;
      if (!held0) new_req(0);
      if (!held1) new_req(1);
      rst_n = ($urandom_range(0, 149) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported data memory between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Round-robin arbitration on a valid/ready request handshake; drives the memory's addr/wdata/mem_read/mem_write lines directly.
- Read data is registered and returned one cycle later with a pulse on rvalid.
- Optional lock holds memory ownership for one port across back-to-back transactions, bounded by a cycle limit.

Parameters:
- ADDR_W, 32, address width (passed through unmodified; memory decodes word index addr[9:2])
- DATA_W, 32, data width
- LOCK_MAX, 8, max cycles a port may hold a lock after the locking transaction (>=1)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  port 0 transaction request
- req0_we  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  byte address
- req0_wdata  in  DATA_W  write data
- req0_lock  in  1  keep ownership after this transaction
- req0_ready  out  1  transaction accepted this cycle
- req0_rvalid  out  1  one-cycle pulse, read data valid
- req0_rdata  out  DATA_W  registered read data
- req1_*  same set as port 0, for port 1
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory wdata
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset: synchronous. When rst_n=0 at a posedge: state=IDLE, last_grant=1 (port 0 wins the first tie), lock_cnt=0, reqN_rvalid=0, reqN_rdata=0.
- While rst_n=0, combinational outputs are forced: reqN_ready=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. No memory write can occur during reset.
- A transaction completes when reqN_valid and reqN_ready are both 1 in the same cycle. Requesters hold valid, we, addr, wdata and lock stable until ready.
- Grant (combinational, at most one port per cycle):
  - IDLE: only one port valid -> grant that port. Both valid -> grant the port != last_grant.
  - LOCKn: only port n may be granted; the other port's ready=0 even when it is valid.
- reqN_ready = grant to port N.
- Memory drive:
  - mem_addr/mem_wdata = granted port's addr/wdata; 0 when there is no grant.
  - mem_read = grant & !we; mem_write = grant & we.
  - Write takes effect at the same posedge (zero latency).
- Read response: on a granted read, mem_rdata is captured into reqN_rdata at the posedge. reqN_rvalid=1 for exactly the next cycle. reqN_rdata holds its value until the next read on that port. Writes produce no rvalid.
- last_grant updates to the granted port on every grant and is unchanged when there is no grant.
- FSM states IDLE, LOCK0, LOCK1:
  - IDLE -> LOCKn: port n granted with reqn_lock=1; lock_cnt <= 0.
  - LOCKn -> IDLE: port n granted with reqn_lock=0.
  - LOCKn -> IDLE (forced): lock_cnt == LOCK_MAX-1. That cycle's grant to port n is still allowed. last_grant=n, so the other port wins the next tie.
  - Otherwise stay in LOCKn, lock_cnt increments every cycle in LOCKn, including cycles where port n is idle.
  - Granted with lock=1 in the forced-release cycle: still go to IDLE, no re-lock that cycle.
- Simultaneous events:
  - Both ports valid in IDLE with port 0 lock=1 and port 0 winning: port 0 granted, next state LOCK0, port 1 stalls.
  - Reset asserted mid-lock or with an rvalid pending: immediate return to reset values; the pending rvalid is dropped.
- No combinational path from mem_rdata to any output.

Decomposition:
- Shared include dmem_arb_defs: state encodings ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2; port index constants P0=1'b0, P1=1'b1.
- One natural sub-module: rr_arb2 (2-way round-robin picker).
  - Inputs: req[1:0], last_grant, mask[1:0].
  - Output: one-hot gnt[1:0].
  - Instantiated once; the FSM supplies mask for lock states.

Test Plan:
- Port 0 write addr=0x10 wdata=0xDEADBEEF, then read addr=0x10 -> ready=1 same cycle both times; mem_write=1 in the write cycle; req0_rvalid pulses 1 cycle after the read with req0_rdata=0xDEADBEEF.
- Both ports request reads every cycle for 4 cycles, from reset -> grants alternate P0,P1,P0,P1; each port sees rvalid on the cycle after its grant; never two grants in one cycle.
- Port 1 writes 3 words with lock=1,1,0 while port 0 continuously requests -> port 1 granted 3 consecutive transactions; req0_ready=0 throughout; port 0 granted on the next cycle.
- LOCK_MAX=8, port 0 locks then idles while port 1 is valid -> port 1 blocked for exactly 8 cycles, granted on the 9th cycle after the locking transaction.
- rst_n=0 for 1 cycle while in LOCK1 with a read rvalid pending -> rvalid=0, rdata=0, state IDLE next cycle; mem_write=0 during the reset cycle even though req1_valid=1 and we=1.
- Single requester port 1 only, read addr=0x3FC -> granted immediately, mem_addr=0x3FC, mem_read=1, req1_rvalid pulses 1 cycle later.
